fp_mul_round_pipe: RTL and testbench
====================================

// Module: fp_mul_round_pipe
// PURPOSE
//  Two-stage pipelined normalise-and-round back end for the IEEE-754 multiplier.
//  Takes the raw significand product, sign and pre-rounding exponent. Produces a
//  packed binary32/binary64 result plus inexact/overflow/underflow flags.
//  Supports five rounding modes and renormalises after a rounding carry.
//  Uses a valid/ready handshake on both sides, so it can stall behind a busy consumer.
// PARAMETERS
//  EXP_W   8    exponent field width (11 for double)
//  MAN_W   23   stored mantissa width (52 for double)
//  PROD_W  2*(MAN_W+1) product width, derived, not overridden
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous, active-low reset
//  in_valid    in   1              input beat valid
//  in_ready    out  1              block accepts beat this cycle
//  in_sign     in   1              result sign
//  in_exp      in   EXP_W+2        signed biased exponent, before normalisation (ea+eb-bias)
//  in_prod     in   PROD_W         unsigned product, 2 integer bits: value = in_prod/2^(PROD_W-2)
//  in_rm       in   3              000 RTZ, 001 +inf, 010 -inf, 011 RNE, 100 RMM; others = RNE
//  out_valid   out  1              result valid
//  out_ready   in   1              consumer accepts result
//  out_result  out  1+EXP_W+MAN_W  packed {sign, exp, mant}
//  out_inexact out  1              discarded bits nonzero, or overflow/underflow occurred
//  out_overflow  out 1             rounded exponent >= 2^EXP_W-1
//  out_underflow out 1             normalised exponent <= 0 (flush to zero)
// BEHAVIOUR
//  - Reset: both stage valids 0; out_result 0; all flags 0; in_ready 1 once reset is released.
//    Reset asserted mid-operation discards in-flight beats.
//  - Transfer occurs when valid&&ready. Latency is 2 cycles from input transfer to out_valid.
//    Throughput is 1/cycle while out_ready=1.
//  - Stall: a stage advances when its downstream slot is empty or draining.
//    in_ready = !s1_v || (!s2_v || out_ready). The stages hold data while stalled.
//    out_* is stable while out_valid && !out_ready. No loss; order is preserved.
//  - S1 (normalise): t = in_prod[PROD_W-1].
//    If t=1: e = in_exp+1; mantissa = prod[PROD_W-2 -: MAN_W]; G = next bit; S = OR of the rest.
//    If t=0: e = in_exp; shift the window down 1 bit.
//    Compute L = mantissa LSB, then the increment:
//      RTZ: 0
//      +inf: !sign && (G|S)
//      -inf: sign && (G|S)
//      RNE: G && (S|L)
//      RMM: G
//    Register sign, e, mantissa, increment, inexact = G|S, rm.
//  - S2 (round/pack): m = {1'b0, mantissa} + increment.
//    On carry out: mantissa = 0 and e = e+1.
//    Exception checks, in priority order:
//      e <= 0 (checked on the S1 exponent): result = {sign, 0}; underflow=1, inexact=1.
//        No subnormals are produced.
//      e >= 2^EXP_W-1: overflow=1, inexact=1.
//        RNE/RMM give inf.
//        RTZ gives max finite.
//        +inf gives +inf if positive, -max finite if negative.
//        -inf gives -inf if negative, +max finite if positive.
//  - in_prod == 0: signed zero, no flags, regardless of in_exp.
//  - NaN/inf/zero operands are resolved upstream; this block does not see them.
//  - All exponent arithmetic is EXP_W+2 bit signed, so it never wraps.
// STRUCTURE
//  - Package fp_pkg: round-mode localparams (RM_RTZ..RM_RMM), fmt_t fields, and the
//    functions max_finite(sign) and inf(sign).
//  - One sub-module, fp_round_inc, holds the combinational increment decision
//    (rm, sign, L, G, S -> inc). It is reused by the adder back end. The rest is inline.
// TESTING (binary32, RNE unless stated, out_ready=1)
//  1. sign=0, exp=127, prod=48'h600000_000000 -> 2 cycles later 32'h3FC00000, no flags
//  2. exp=127, prod=48'h400000_400000 (tie, L=0): RNE -> 3F800000; +inf -> 3F800001;
//     inexact=1 in both
//  3. exp=127, prod=48'h7FFFFF_C00000 -> carry renormalise -> 32'h40000000, inexact=1;
//     prod=48'h800000_000000 -> 40000000, exact
//  4. exp=254, prod=48'h800000_000000: RNE -> 7F800000, ovf+inx; RTZ -> 7F7FFFFF;
//     sign=1 with +inf -> FF7FFFFF
//  5. exp=0, prod=48'h400000_000000, sign=1 -> 80000000, underflow=1, inexact=1
//  6. Stream 4 beats with out_ready low for 5 cycles:
//     in_ready drops after 2 beats are accepted; outputs are held stable;
//     all 4 results come out in order; asserting rst_n mid-stream clears out_valid at once.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point back ends: rounding-mode codes,
// format descriptor and the special-value builders used on overflow.
package fp_pkg;

    // Rounding-mode encodings on the 3-bit rm input; unlisted codes behave as RNE.
    localparam logic [2:0] RM_RTZ = 3'b000;
    localparam logic [2:0] RM_RPI = 3'b001;
    localparam logic [2:0] RM_RNI = 3'b010;
    localparam logic [2:0] RM_RNE = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Field widths of a packed format {sign, exp, mant}. binary64 uses 11/52.
    typedef struct packed {
        int unsigned exp_w;
        int unsigned man_w;
    } fmt_t;

    localparam fmt_t FMT_B32 = '{exp_w: 8, man_w: 23};

    // Largest finite magnitude with the given sign, right-aligned in 64 bits.
    function automatic logic [63:0] max_finite(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << (exp_w + man_w)) - 64'd1) - (64'd1 << man_w);
        r = r | ({63'd0, sign} << (exp_w + man_w));
        return r;
    endfunction

    // Infinity with the given sign, right-aligned in 64 bits.
    function automatic logic [63:0] inf(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | ({63'd0, sign} << (exp_w + man_w));
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_round_pipe_if.sv
// Input and output channels of the multiplier round/pack back end.
interface fp_mul_round_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = FMT_B32.exp_w,
    parameter int MAN_W = FMT_B32.man_w
);
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int RES_W  = 1 + EXP_W + MAN_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W+1:0]  in_exp;
    logic [PROD_W-1:0] in_prod;
    logic [2:0]        in_rm;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic              out_inexact;
    logic              out_overflow;
    logic              out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_rm, out_ready,
        input  in_ready, out_valid, out_result, out_inexact, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_rm, out_ready,
        output in_ready, out_valid, out_result, out_inexact, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_round_inc.sv
// Round-up decision from rounding mode, sign and the L/G/S bits.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    // Pick the increment rule for the selected rounding mode.
    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RPI:  inc = !sign && (guard || sticky);
            RM_RNI:  inc = sign && (guard || sticky);
            RM_RMM:  inc = guard;
            default: inc = guard && (sticky || lsb);   // RNE and reserved codes
        endcase
    end

endmodule

// File: rtl/fp_mul_round_pipe.sv
// Two-stage normalise / round-and-pack back end for the multiplier.
// Stage 1 normalises the product and decides the increment; stage 2 applies it,
// handles the rounding carry, and resolves underflow / overflow.
module fp_mul_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FMT_B32.exp_w,
    parameter int MAN_W = FMT_B32.man_w
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_mul_round_pipe_if.slave bus
);

    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int RES_W  = 1 + EXP_W + MAN_W;
    localparam int E_W    = EXP_W + 2;

    localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
    localparam logic signed [E_W-1:0] E_OVF = E_W'((1 << EXP_W) - 1);

    // Stage 1 registers
    logic                    s1_v_q,    s1_v_d;
    logic                    s1_sign_q, s1_sign_d;
    logic signed [E_W-1:0]   s1_e_q,    s1_e_d;
    logic [MAN_W-1:0]        s1_mant_q, s1_mant_d;
    logic                    s1_inc_q,  s1_inc_d;
    logic                    s1_inx_q,  s1_inx_d;
    logic [2:0]              s1_rm_q,   s1_rm_d;
    logic                    s1_zero_q, s1_zero_d;

    // Stage 2 (output) registers
    logic                    s2_v_q,      s2_v_d;
    logic [RES_W-1:0]        s2_result_q, s2_result_d;
    logic                    s2_inx_q,    s2_inx_d;
    logic                    s2_ovf_q,    s2_ovf_d;
    logic                    s2_unf_q,    s2_unf_d;

    // Stage 1 combinational signals
    logic                    top_bit;
    logic [PROD_W-2:0]       norm;
    logic [MAN_W-1:0]        mant_n;
    logic                    guard_n;
    logic                    sticky_n;
    logic                    inc_n;
    logic signed [E_W-1:0]   e_n;

    // Stage 2 combinational signals
    logic [MAN_W:0]          m_sum;
    logic                    carry;
    logic signed [E_W-1:0]   e_r;

    logic s1_adv;
    logic s2_adv;

    // A slot can take new data when it is empty or its contents leave this cycle.
    assign s2_adv = !s2_v_q || bus.out_ready;
    assign s1_adv = !s1_v_q || s2_adv;

    // Normalise: drop the leading integer bit position so the hidden 1 sits at the top.
    always_comb begin
        top_bit  = bus.in_prod[PROD_W-1];
        norm     = top_bit ? bus.in_prod[PROD_W-2:0] : {bus.in_prod[PROD_W-3:0], 1'b0};
        mant_n   = norm[PROD_W-2 -: MAN_W];
        guard_n  = norm[PROD_W-2-MAN_W];
        sticky_n = |norm[PROD_W-3-MAN_W:0];
        e_n      = $signed(bus.in_exp) + $signed({{(E_W-1){1'b0}}, top_bit});
    end

    fp_round_inc u_round_inc (
        .rm     (bus.in_rm),
        .sign   (bus.in_sign),
        .lsb    (mant_n[0]),
        .guard  (guard_n),
        .sticky (sticky_n),
        .inc    (inc_n)
    );

    // Stage 1 next state: capture a beat on transfer, otherwise hold.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_sign_d = s1_sign_q;
        s1_e_d    = s1_e_q;
        s1_mant_d = s1_mant_q;
        s1_inc_d  = s1_inc_q;
        s1_inx_d  = s1_inx_q;
        s1_rm_d   = s1_rm_q;
        s1_zero_d = s1_zero_q;
        if (s1_adv) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = bus.in_sign;
                s1_e_d    = e_n;
                s1_mant_d = mant_n;
                s1_inc_d  = inc_n;
                s1_inx_d  = guard_n || sticky_n;
                s1_rm_d   = bus.in_rm;
                s1_zero_d = (bus.in_prod == '0);
            end
        end
    end

    // Apply the increment; an all-ones mantissa carries out, leaving zeros and bumping e.
    always_comb begin
        m_sum = {1'b0, s1_mant_q} + {{MAN_W{1'b0}}, s1_inc_q};
        carry = m_sum[MAN_W];
        e_r   = s1_e_q + $signed({{(E_W-1){1'b0}}, carry});
    end

    // Stage 2 next state: pack the result with zero > underflow > overflow priority.
    always_comb begin
        s2_v_d      = s2_v_q;
        s2_result_d = s2_result_q;
        s2_inx_d    = s2_inx_q;
        s2_ovf_d    = s2_ovf_q;
        s2_unf_d    = s2_unf_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_inx_d    = s1_inx_q;
                s2_ovf_d    = 1'b0;
                s2_unf_d    = 1'b0;
                s2_result_d = {s1_sign_q, e_r[EXP_W-1:0], m_sum[MAN_W-1:0]};
                if (s1_zero_q) begin
                    s2_result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
                    s2_inx_d    = 1'b0;
                end else if (s1_e_q < E_ONE) begin
                    // No subnormals: flush to signed zero.
                    s2_result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
                    s2_unf_d    = 1'b1;
                    s2_inx_d    = 1'b1;
                end else if (e_r >= E_OVF) begin
                    s2_ovf_d = 1'b1;
                    s2_inx_d = 1'b1;
                    case (s1_rm_q)
                        RM_RTZ:  s2_result_d = RES_W'(max_finite(s1_sign_q, EXP_W, MAN_W));
                        RM_RPI:  s2_result_d = s1_sign_q ? RES_W'(max_finite(s1_sign_q, EXP_W, MAN_W))
                                                         : RES_W'(inf(s1_sign_q, EXP_W, MAN_W));
                        RM_RNI:  s2_result_d = s1_sign_q ? RES_W'(inf(s1_sign_q, EXP_W, MAN_W))
                                                         : RES_W'(max_finite(s1_sign_q, EXP_W, MAN_W));
                        default: s2_result_d = RES_W'(inf(s1_sign_q, EXP_W, MAN_W));
                    endcase
                end
            end
        end
    end

    // Pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_e_q      <= '0;
            s1_mant_q   <= '0;
            s1_inc_q    <= 1'b0;
            s1_inx_q    <= 1'b0;
            s1_rm_q     <= '0;
            s1_zero_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_result_q <= '0;
            s2_inx_q    <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_sign_q   <= s1_sign_d;
            s1_e_q      <= s1_e_d;
            s1_mant_q   <= s1_mant_d;
            s1_inc_q    <= s1_inc_d;
            s1_inx_q    <= s1_inx_d;
            s1_rm_q     <= s1_rm_d;
            s1_zero_q   <= s1_zero_d;
            s2_v_q      <= s2_v_d;
            s2_result_q <= s2_result_d;
            s2_inx_q    <= s2_inx_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_unf_q    <= s2_unf_d;
        end
    end

    assign bus.in_ready      = s1_adv;
    assign bus.out_valid     = s2_v_q;
    assign bus.out_result    = s2_result_q;
    assign bus.out_inexact   = s2_inx_q;
    assign bus.out_overflow  = s2_ovf_q;
    assign bus.out_underflow = s2_unf_q;

endmodule

// File: tb/tb_fp_mul_round_pipe.sv
// Directed bench for fp_mul_round_pipe (binary32).
module tb_fp_mul_round_pipe;
    import fp_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mul_round_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.out_inexact, bus.out_overflow, bus.out_underflow};
    endfunction

    // One isolated beat: drive, wait for the result, check latency/result/flags {inx,ovf,unf}.
    task automatic vec(input string tag, input logic s, input logic [9:0] e, input logic [47:0] p,
                       input logic [2:0] rm, input logic [31:0] exp_res, input logic [2:0] exp_flg);
        int n;
        bit found;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_prod  = p;
        bus.in_rm    = rm;
        @(posedge clk);
        n = 0;
        found = 1'b0;
        while (!found && n < 8) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
            if (bus.out_valid) found = 1'b1;
        end
        chk({tag, "_valid"}, 64'(found), 64'd1);
        if (found) begin
            chk({tag, "_lat"}, 64'(n), 64'd2);
            chk({tag, "_res"}, 64'(bus.out_result), 64'(exp_res));
            chk({tag, "_flg"}, 64'(flags()), 64'(exp_flg));
        end
        $display("vec %s result=%08h flags=%03b", tag, bus.out_result, flags());
    endtask

    // Stream beats
    logic        sb_sign [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [47:0] sb_prod [4] = '{48'h600000_000000, 48'h600000_000000, 48'h800000_000000, 48'h400000_400000};
    logic [2:0]  sb_rm   [4] = '{RM_RNE, RM_RNE, RM_RNE, RM_RPI};
    logic [31:0] sb_exp  [4] = '{32'h3FC00000, 32'hBFC00000, 32'h40000000, 32'h3F800001};

    task automatic drive_beat(input int i);
        bus.in_valid = 1'b1;
        bus.in_sign  = sb_sign[i];
        bus.in_exp   = 10'd127;
        bus.in_prod  = sb_prod[i];
        bus.in_rm    = sb_rm[i];
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, outidx;
        bit held, drop_seen;
        logic [31:0] held_val;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_prod   = '0;
        bus.in_rm     = RM_RNE;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_flags", 64'(flags()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        $display("reset released in_ready=%0b", bus.in_ready);

        // Normal path and rounding
        vec("t1",        1'b0, 10'd127, 48'h600000_000000, RM_RNE, 32'h3FC00000, 3'b000);
        vec("t1_neg",    1'b1, 10'd127, 48'h600000_000000, RM_RNE, 32'hBFC00000, 3'b000);
        vec("tie_rne",   1'b0, 10'd127, 48'h400000_400000, RM_RNE, 32'h3F800000, 3'b100);
        vec("tie_rpi",   1'b0, 10'd127, 48'h400000_400000, RM_RPI, 32'h3F800001, 3'b100);
        vec("tie_rtz",   1'b0, 10'd127, 48'h400000_400000, RM_RTZ, 32'h3F800000, 3'b100);
        vec("tie_rni",   1'b0, 10'd127, 48'h400000_400000, RM_RNI, 32'h3F800000, 3'b100);
        vec("tie_rmm",   1'b0, 10'd127, 48'h400000_400000, RM_RMM, 32'h3F800001, 3'b100);
        vec("tie_rm7",   1'b0, 10'd127, 48'h400000_400000, 3'b111, 32'h3F800000, 3'b100);
        vec("gs_rne",    1'b0, 10'd127, 48'h400000_400001, RM_RNE, 32'h3F800001, 3'b100);
        vec("s_only",    1'b0, 10'd127, 48'h400000_200000, RM_RNE, 32'h3F800000, 3'b100);
        vec("s_only_up", 1'b0, 10'd127, 48'h400000_200000, RM_RPI, 32'h3F800001, 3'b100);
        vec("carry",     1'b0, 10'd127, 48'h7FFFFF_C00000, RM_RNE, 32'h40000000, 3'b100);
        vec("top1",      1'b0, 10'd127, 48'h800000_000000, RM_RNE, 32'h40000000, 3'b000);

        // Overflow
        vec("ovf_rne",   1'b0, 10'd254, 48'h800000_000000, RM_RNE, 32'h7F800000, 3'b110);
        vec("ovf_rtz",   1'b0, 10'd254, 48'h800000_000000, RM_RTZ, 32'h7F7FFFFF, 3'b110);
        vec("ovf_rpi_n", 1'b1, 10'd254, 48'h800000_000000, RM_RPI, 32'hFF7FFFFF, 3'b110);
        vec("ovf_rni_n", 1'b1, 10'd254, 48'h800000_000000, RM_RNI, 32'hFF800000, 3'b110);
        vec("ovf_rni_p", 1'b0, 10'd254, 48'h800000_000000, RM_RNI, 32'h7F7FFFFF, 3'b110);
        vec("ovf_carry", 1'b0, 10'd254, 48'h7FFFFF_C00000, RM_RNE, 32'h7F800000, 3'b110);
        vec("max_exp",   1'b0, 10'd253, 48'h800000_000000, RM_RNE, 32'h7F000000, 3'b000);

        // Underflow and zero
        vec("unf",       1'b1, 10'd0,   48'h400000_000000, RM_RNE, 32'h80000000, 3'b101);
        vec("unf_edge",  1'b0, 10'h3FF, 48'h800000_000000, RM_RNE, 32'h00000000, 3'b101);
        vec("min_norm",  1'b0, 10'd0,   48'h800000_000000, RM_RNE, 32'h00800000, 3'b000);
        vec("zero_neg",  1'b1, 10'd0,   48'h000000_000000, RM_RNE, 32'h80000000, 3'b000);
        vec("zero_big",  1'b0, 10'd300, 48'h000000_000000, RM_RPI, 32'h00000000, 3'b000);

        // Back-pressure stream: out_ready low for the first 5 cycles
        idx = 0;
        outidx = 0;
        held = 1'b0;
        drop_seen = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 5);
            #1;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (outidx < 4) chk($sformatf("s6_out%0d", outidx), 64'(bus.out_result), 64'(sb_exp[outidx]));
                    $display("stream out %0d result=%08h", outidx, bus.out_result);
                    outidx++;
                    held = 1'b0;
                end else if (held) begin
                    chk("s6_hold", 64'(bus.out_result), 64'(held_val));
                end else begin
                    held = 1'b1;
                    held_val = bus.out_result;
                end
            end
            if (idx < 4 && !bus.in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                chk("s6_drop_after", 64'(idx), 64'd2);
            end
            if (idx < 4 && bus.in_ready) begin
                drive_beat(idx);
                idx++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        chk("s6_count", 64'(outidx), 64'd4);
        chk("s6_drop_seen", 64'(drop_seen), 64'd1);

        // Reset in the middle of a stalled stream
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mrst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_result", 64'(bus.out_result), 64'd0);
        chk("mrst_flags", 64'(flags()), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        $display("mid-stream reset out_valid=%0b", bus.out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_flushed%0d", k), 64'(bus.out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
